stopwatch_timer: RTL
====================

// Module: stopwatch_timer
// PURPOSE
// - Parametrised successor of the board stopwatch: ms up-counter / programmable countdown timer.
// - Owns its own ms prescaler, so the time base is exact regardless of board clock.
// - Sits between the debounced switch/button inputs and the 7-seg decoder / sound module.
// - Adds start/stop pulses, saturation, expiry handling and a programmable preset fallback.
// PARAMETERS
// - CLK_HZ     100_000_000  board clock frequency
// - TICK_HZ    1000         count rate (1 LSB of t_out = 1/TICK_HZ s)
// - W          23           time width; must satisfy 2**W > MAX_T
// - MAX_T      3_599_999    limit in ticks (59:59.999)
// - PRESET_T   60_000       countdown start used when prog_t==0 (1 min)
// - MIN_STEP   60_000       program increment with min=1
// - SEC_STEP   1_000        program increment with min=0
// PORTS
// - clk         in   1  board clock
// - rst         in   1  synchronous, active-high reset
// - s           in   1  start/stop toggle, one-cycle debounced pulse
// - p           in   1  program-mode level switch
// - u           in   1  1=count up, 0=count down (level)
// - clr         in   1  time clear pulse (run reset)
// - inc         in   1  program increment pulse
// - min         in   1  increment size select: 1=MIN_STEP, 0=SEC_STEP
// - t_out       out  W  displayed time in ticks
// - prog_t      out  W  programmed countdown time
// - running     out  1  high in RUN
// - zero        out  1  high while countdown expired (to sound module)
// - sat         out  1  high while up-count is held at MAX_T
// BEHAVIOUR
// - Reset: state=IDLE, t_out=0, prog_t=0, running=0, zero=0, sat=0, prescaler=0.
// - Prescaler: tick is high 1 cycle every DIV=CLK_HZ/TICK_HZ cycles.
//   - Counts only in RUN; cleared on entry to RUN and on any exit from RUN.
//   - First tick therefore arrives DIV cycles after the s pulse.
// - Load value: LD = u ? 0 : (prog_t!=0 ? prog_t : PRESET_T).
// - States: IDLE, PROG, RUN, PAUSE, DONE.
// - Priority per cycle: rst > p > u change > clr > s > tick.
// - p=1 in any state -> PROG next cycle.
//   - In PROG: t_out=prog_t; inc adds step to prog_t, saturating at MAX_T.
//   - p falling -> IDLE with t_out=LD.
// - u toggles (edge vs registered u) in any non-PROG state -> IDLE, t_out=LD.
// - IDLE: t_out=LD; s -> RUN.
// - RUN: on tick, t_out +1 (up) or -1 (down).
//   - Up: t_out==MAX_T at tick -> stays MAX_T, sat=1, -> DONE.
//   - Down: t_out==1 at tick -> t_out=0, zero=1, -> DONE.
//   - s -> PAUSE; if tick is in the same cycle, the tick is applied first.
//   - clr -> IDLE, t_out=LD.
// - PAUSE: t_out held; s -> RUN; clr -> IDLE, t_out=LD.
// - DONE: t_out held.
//   - zero/sat stay high until clr, u change, p or rst (all return to IDLE, flags cleared).
//   - s ignored.
// - Down mode with LD==0 cannot occur (PRESET_T>0); a down-count never wraps below 0.
// - All outputs registered; t_out changes the cycle after the tick edge.
// - Arithmetic is unsigned W-bit; prog_t += step is computed at W+1 bits before the saturation compare.
// STRUCTURE
// - Shared package: state encodings (one-hot, 5 states), step constants, ms_per_min/sec.
// - One sub-module: tick_gen (CLK_HZ, TICK_HZ; ports clk, rst, en, tick), reused by other timers.
// - The FSM and counters live in this module: single registered always block plus next-state logic.
// TESTING (bench params: CLK_HZ=10, TICK_HZ=1 -> DIV=10; MAX_T=20, PRESET_T=5, MIN_STEP=4, SEC_STEP=1)
// - rst, u=1, pulse s, wait 35 cycles -> t_out=3, running=1; pulse s -> t_out holds 3 for 50 cycles.
// - u=1 run to limit -> t_out=20, sat=1, running=0; pulse clr -> t_out=0, sat=0, state IDLE.
// - u=0, prog_t=0, pulse s, wait 50 cycles -> t_out=0, zero=1; holds; clr -> t_out=5, zero=0.
// - p=1, inc x2 with min=1 then inc x1 with min=0 -> prog_t=9; p=0, u=0 -> t_out=9.
//   - Then 5 more min incs -> prog_t saturates at 20.
// - Simultaneous s and tick in RUN: count applied, then PAUSE (t_out incremented once, running=0).
// - rst asserted mid-RUN at t_out=7 -> next cycle all outputs zero, prog_t=0; clr+s together in PAUSE -> IDLE.

Source files
------------

// File: rtl/stopwatch_timer_pkg.sv
// Shared definitions for the stopwatch/countdown timer family:
// one-hot state encodings, time-step constants and the prescaler divide helper.
package stopwatch_timer_pkg;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_PROG  = 5'b00010,
        ST_RUN   = 5'b00100,
        ST_PAUSE = 5'b01000,
        ST_DONE  = 5'b10000
    } state_e;

    localparam int unsigned MS_PER_SEC   = 1000;
    localparam int unsigned MS_PER_MIN   = 60 * MS_PER_SEC;
    localparam int unsigned DEF_SEC_STEP = MS_PER_SEC;
    localparam int unsigned DEF_MIN_STEP = MS_PER_MIN;

    function automatic int unsigned clk_div(input int unsigned clk_hz, input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/stopwatch_timer_tick_gen.sv
// Prescaler: one-cycle tick every CLK_HZ/TICK_HZ enabled cycles.
// Held at zero while disabled, so every enable starts a full fresh period.
module stopwatch_timer_tick_gen
    import stopwatch_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned DIV = clk_div(CLK_HZ, TICK_HZ);
    localparam int          CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = en_i && (cnt_q == TERM);
        cnt_d  = cnt_q;
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_timer.sv
// Millisecond up-counter / programmable countdown timer with its own prescaler,
// saturation at MAX_T, expiry flag and a preset fallback for an unprogrammed countdown.
module stopwatch_timer
    import stopwatch_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned W        = 23,
    parameter int unsigned MAX_T    = 3_599_999,
    parameter int unsigned PRESET_T = 60_000,
    parameter int unsigned MIN_STEP = DEF_MIN_STEP,
    parameter int unsigned SEC_STEP = DEF_SEC_STEP
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         s_i,
    input  logic         p_i,
    input  logic         u_i,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         min_i,
    output logic [W-1:0] t_out_o,
    output logic [W-1:0] prog_t_o,
    output logic         running_o,
    output logic         zero_o,
    output logic         sat_o
);

    localparam logic [W-1:0] MAX_V    = W'(MAX_T);
    localparam logic [W-1:0] PRESET_V = W'(PRESET_T);
    localparam logic [W-1:0] ONE      = W'(1);
    localparam logic [W:0]   MIN_S    = (W+1)'(MIN_STEP);
    localparam logic [W:0]   SEC_S    = (W+1)'(SEC_STEP);
    localparam logic [W:0]   MAX_X    = (W+1)'(MAX_T);

    state_e       state_q, state_d;
    logic [W-1:0] t_q, t_d;
    logic [W-1:0] prog_q, prog_d;
    logic         running_q, running_d;
    logic         zero_q, zero_d;
    logic         sat_q, sat_d;
    logic         u_q;
    logic         tick;
    logic [W-1:0] ld;
    logic [W:0]   sum;

    stopwatch_timer_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (state_q == ST_RUN),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        prog_d  = prog_q;
        zero_d  = zero_q;
        sat_d   = sat_q;
        ld      = u_i ? '0 : ((prog_q != '0) ? prog_q : PRESET_V);
        sum     = {1'b0, prog_q} + (min_i ? MIN_S : SEC_S);

        if (p_i) begin
            state_d = ST_PROG;
            zero_d  = 1'b0;
            sat_d   = 1'b0;
            if (state_q == ST_PROG && inc_i) begin
                prog_d = (sum > MAX_X) ? MAX_V : sum[W-1:0];
            end
            t_d = prog_d;
        end else if (state_q == ST_PROG || u_i != u_q || clr_i) begin
            // Leaving programming, flipping direction and clear all restart from the load value.
            state_d = ST_IDLE;
            t_d     = ld;
            zero_d  = 1'b0;
            sat_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    t_d = ld;
                    if (s_i) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (s_i) state_d = ST_PAUSE;
                    if (tick) begin
                        if (u_i) begin
                            if (t_q >= MAX_V) begin
                                t_d     = MAX_V;
                                sat_d   = 1'b1;
                                state_d = ST_DONE;
                            end else begin
                                t_d = t_q + ONE;
                            end
                        end else if (t_q <= ONE) begin
                            t_d     = '0;
                            zero_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            t_d = t_q - ONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (s_i) state_d = ST_RUN;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    t_d     = ld;
                end
            endcase
        end
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            t_q       <= '0;
            prog_q    <= '0;
            running_q <= 1'b0;
            zero_q    <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            prog_q    <= prog_d;
            running_q <= running_d;
            zero_q    <= zero_d;
            sat_q     <= sat_d;
        end
    end

    // Tracks u through reset so a switch already set at power-up is not seen as a change.
    always_ff @(posedge clk_i) begin
        u_q <= u_i;
    end

    assign t_out_o   = t_q;
    assign prog_t_o  = prog_q;
    assign running_o = running_q;
    assign zero_o    = zero_q;
    assign sat_o     = sat_q;

endmodule
